// File: rtl/vector_pkg.sv
// Shared definitions for the vector display sequencer: phase encoding,
// command type constants and default widths.
package vector_pkg;

    localparam int DEF_W  = 12;
    localparam int DEF_ZW = 8;

    localparam logic CMD_JUMP = 1'b0;
    localparam logic CMD_DRAW = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_MOVE = 2'd2,
        ST_POST = 2'd3
    } seq_state_e;

    // Which point the output register loads on the next edge.
    typedef enum logic [2:0] {
        EMIT_NONE = 3'd0,
        EMIT_HOLD = 3'd1,
        EMIT_CUR  = 3'd2,
        EMIT_LINE = 3'd3,
        EMIT_TGT  = 3'd4
    } emit_e;

    function automatic logic is_draw(input logic cmd_type);
        return cmd_type == CMD_DRAW;
    endfunction

endpackage

// File: rtl/vector_sequencer_line_stepper.sv
// Bresenham line core. nx/ny show the point the next step lands on; with load
// and step together the first step is taken straight from the load inputs.
module line_stepper
    import vector_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic [W-1:0] nx,
    output logic [W-1:0] ny,
    output logic         done
);

    localparam int EW = W + 2;

    logic [W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [W-1:0] maj_q, maj_d, min_q, min_d, cnt_q, cnt_d;
    logic         sx_q, sx_d, sy_q, sy_d, xmaj_q, xmaj_d;
    logic signed [EW-1:0] err_q, err_d;

    logic [W-1:0] ld_dx, ld_dy, ld_maj, ld_min;
    logic signed [EW:0] ld_err;
    logic [W-1:0] w_x, w_y, w_tx, w_ty, w_maj, w_min, w_cnt;
    logic         w_sx, w_sy, w_xmaj;
    logic signed [EW-1:0] w_err;
    logic         minor_step;
    logic [W-1:0] fx, fy;
    logic signed [EW:0] min2, maj2, err_next;

    // Working set: freshly derived line parameters on load, stored ones otherwise.
    always_comb begin
        ld_dx  = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        ld_dy  = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        ld_maj = (ld_dx >= ld_dy) ? ld_dx : ld_dy;
        ld_min = (ld_dx >= ld_dy) ? ld_dy : ld_dx;
        ld_err = $signed({2'b00, ld_min, 1'b0}) - $signed({3'b000, ld_maj});
        if (load) begin
            w_x    = x0;
            w_y    = y0;
            w_tx   = x1;
            w_ty   = y1;
            w_maj  = ld_maj;
            w_min  = ld_min;
            w_cnt  = ld_maj;
            w_sx   = (x1 < x0);
            w_sy   = (y1 < y0);
            w_xmaj = (ld_dx >= ld_dy);
            w_err  = ld_err[EW-1:0];
        end else begin
            w_x    = pos_x_q;
            w_y    = pos_y_q;
            w_tx   = tgt_x_q;
            w_ty   = tgt_y_q;
            w_maj  = maj_q;
            w_min  = min_q;
            w_cnt  = cnt_q;
            w_sx   = sx_q;
            w_sy   = sy_q;
            w_xmaj = xmaj_q;
            w_err  = err_q;
        end
    end

    // One Bresenham step; the final step snaps onto the target.
    always_comb begin
        minor_step = !w_err[EW-1] && (w_err != '0);
        fx         = w_sx ? (w_x - W'(1)) : (w_x + W'(1));
        fy         = w_sy ? (w_y - W'(1)) : (w_y + W'(1));
        min2       = $signed({2'b00, w_min, 1'b0});
        maj2       = minor_step ? $signed({2'b00, w_maj, 1'b0}) : $signed({(EW+1){1'b0}});
        err_next   = $signed({w_err[EW-1], w_err}) + min2 - maj2;
        if (w_cnt <= W'(1)) begin
            nx = w_tx;
            ny = w_ty;
        end else if (w_xmaj) begin
            nx = fx;
            ny = minor_step ? fy : w_y;
        end else begin
            nx = minor_step ? fx : w_x;
            ny = fy;
        end
    end

    // Next register values: keep the working set, advance it when stepping.
    always_comb begin
        pos_x_d = w_x;
        pos_y_d = w_y;
        tgt_x_d = w_tx;
        tgt_y_d = w_ty;
        maj_d   = w_maj;
        min_d   = w_min;
        cnt_d   = w_cnt;
        sx_d    = w_sx;
        sy_d    = w_sy;
        xmaj_d  = w_xmaj;
        err_d   = w_err;
        if (step && (w_cnt != '0)) begin
            pos_x_d = nx;
            pos_y_d = ny;
            cnt_d   = w_cnt - W'(1);
            err_d   = err_next[EW-1:0];
        end else begin
            cnt_d   = w_cnt;
        end
    end

    // Line state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            tgt_x_q <= '0;
            tgt_y_q <= '0;
            maj_q   <= '0;
            min_q   <= '0;
            cnt_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            xmaj_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            maj_q   <= maj_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            xmaj_q  <= xmaj_d;
            err_q   <= err_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Command-to-point sequencer: turns jump/draw commands into dwell, move and
// settle points streamed to the DAC side over valid/ready.
module vector_sequencer
    import vector_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int ZW        = DEF_ZW,
    parameter int DWELL_W   = 6,
    parameter int JUMP_PRE  = 2,
    parameter int JUMP_POST = 2,
    parameter int DRAW_PRE  = 3,
    parameter int DRAW_POST = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_draw,
    input  logic [W-1:0]  cmd_x,
    input  logic [W-1:0]  cmd_y,
    input  logic [ZW-1:0] cmd_z,
    output logic          pt_valid,
    input  logic          pt_ready,
    output logic [W-1:0]  pt_x,
    output logic [W-1:0]  pt_y,
    output logic [ZW-1:0] pt_z,
    output logic          busy
);

    seq_state_e state_q, state_d;
    emit_e      emit_s;

    logic [DWELL_W-1:0] dwell_q, dwell_d, pre_cnt, post_cnt;
    logic [W-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [W-1:0]  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [ZW-1:0] z_q, z_d;
    logic          draw_q, draw_d, rdy_q, rdy_d;
    logic          pt_valid_q, pt_valid_d;
    logic [W-1:0]  pt_x_q, pt_x_d, pt_y_q, pt_y_d;
    logic [ZW-1:0] pt_z_q, pt_z_d;

    logic          is_idle, cmd_fire, pt_fire, finish_s, ln_step, ln_done;
    logic          w_draw;
    logic [W-1:0]  w_tx, w_ty, ln_nx, ln_ny;
    logic [ZW-1:0] w_zpt;

    assign is_idle   = (state_q == ST_IDLE);
    assign cmd_ready = is_idle && rdy_q;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign pt_fire   = pt_valid_q && pt_ready;
    assign busy      = !is_idle;
    assign pt_valid  = pt_valid_q;
    assign pt_x      = pt_x_q;
    assign pt_y      = pt_y_q;
    assign pt_z      = pt_z_q;

    // In IDLE the command inputs are live; afterwards the latched copy is used.
    always_comb begin
        w_draw   = is_idle ? cmd_draw : draw_q;
        w_tx     = is_idle ? cmd_x : tgt_x_q;
        w_ty     = is_idle ? cmd_y : tgt_y_q;
        w_zpt    = is_draw(w_draw) ? (is_idle ? cmd_z : z_q) : ZW'(0);
        pre_cnt  = is_draw(w_draw) ? DWELL_W'(DRAW_PRE)  : DWELL_W'(JUMP_PRE);
        post_cnt = is_draw(w_draw) ? DWELL_W'(DRAW_POST) : DWELL_W'(JUMP_POST);
    end

    line_stepper #(.W(W)) u_line (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cmd_fire),
        .step    (ln_step),
        .x0      (cur_x_q),
        .y0      (cur_y_q),
        .x1      (cmd_x),
        .y1      (cmd_y),
        .nx      (ln_nx),
        .ny      (ln_ny),
        .done    (ln_done)
    );

    // Next-state: phases advance on handshakes, empty phases fall straight through.
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        emit_s   = EMIT_HOLD;
        finish_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                emit_s = EMIT_NONE;
                if (cmd_fire) begin
                    if (pre_cnt != '0) begin
                        state_d = ST_PRE;
                        dwell_d = pre_cnt - DWELL_W'(1);
                        emit_s  = EMIT_CUR;
                    end else begin
                        state_d = ST_MOVE;
                        emit_s  = is_draw(w_draw) ? EMIT_LINE : EMIT_TGT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (pt_fire && (dwell_q != '0)) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else if (pt_fire) begin
                    state_d = ST_MOVE;
                    emit_s  = is_draw(w_draw) ? EMIT_LINE : EMIT_TGT;
                end else begin
                    emit_s  = EMIT_HOLD;
                end
            end
            ST_MOVE: begin
                if (pt_fire && is_draw(w_draw) && !ln_done) begin
                    emit_s = EMIT_LINE;
                end else if (pt_fire && (post_cnt != '0)) begin
                    state_d = ST_POST;
                    dwell_d = post_cnt - DWELL_W'(1);
                    emit_s  = EMIT_TGT;
                end else if (pt_fire) begin
                    state_d  = ST_IDLE;
                    emit_s   = EMIT_NONE;
                    finish_s = 1'b1;
                end else begin
                    emit_s = EMIT_HOLD;
                end
            end
            ST_POST: begin
                if (pt_fire && (dwell_q != '0)) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else if (pt_fire) begin
                    state_d  = ST_IDLE;
                    emit_s   = EMIT_NONE;
                    finish_s = 1'b1;
                end else begin
                    emit_s = EMIT_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                emit_s  = EMIT_NONE;
            end
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        pt_valid_d = pt_valid_q;
        pt_x_d     = pt_x_q;
        pt_y_d     = pt_y_q;
        pt_z_d     = pt_z_q;
        ln_step    = 1'b0;
        case (emit_s)
            EMIT_NONE: pt_valid_d = 1'b0;
            EMIT_HOLD: pt_valid_d = pt_valid_q;
            EMIT_CUR: begin
                pt_valid_d = 1'b1;
                pt_x_d     = cur_x_q;
                pt_y_d     = cur_y_q;
                pt_z_d     = w_zpt;
            end
            EMIT_LINE: begin
                pt_valid_d = 1'b1;
                pt_x_d     = ln_nx;
                pt_y_d     = ln_ny;
                pt_z_d     = w_zpt;
                ln_step    = 1'b1;
            end
            EMIT_TGT: begin
                pt_valid_d = 1'b1;
                pt_x_d     = w_tx;
                pt_y_d     = w_ty;
                pt_z_d     = w_zpt;
            end
            default: pt_valid_d = 1'b0;
        endcase
        tgt_x_d = cmd_fire ? cmd_x : tgt_x_q;
        tgt_y_d = cmd_fire ? cmd_y : tgt_y_q;
        z_d     = cmd_fire ? cmd_z : z_q;
        draw_d  = cmd_fire ? cmd_draw : draw_q;
        cur_x_d = finish_s ? tgt_x_q : cur_x_q;
        cur_y_d = finish_s ? tgt_y_q : cur_y_q;
        rdy_d   = 1'b1;
    end

    // State, position and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            dwell_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            z_q        <= '0;
            draw_q     <= CMD_JUMP;
            rdy_q      <= 1'b0;
            pt_valid_q <= 1'b0;
            pt_x_q     <= '0;
            pt_y_q     <= '0;
            pt_z_q     <= '0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            z_q        <= z_d;
            draw_q     <= draw_d;
            rdy_q      <= rdy_d;
            pt_valid_q <= pt_valid_d;
            pt_x_q     <= pt_x_d;
            pt_y_q     <= pt_y_d;
            pt_z_q     <= pt_z_d;
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: command table plus random commands checked
// against a closed-form line model, with reset and zero-dwell corner cases.
module tb_vector_sequencer;

    localparam int W = 12;
    localparam int ZW = 8;
    localparam int JP = 2, JQ = 2, DP = 3, DQ = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_draw, pt_valid, pt_ready, busy;
    logic [W-1:0]  cmd_x, cmd_y, pt_x, pt_y;
    logic [ZW-1:0] cmd_z, pt_z;

    logic          d0_cmd_valid, d0_cmd_ready, d0_cmd_draw, d0_pt_valid, d0_pt_ready, d0_busy;
    logic [W-1:0]  d0_cmd_x, d0_cmd_y, d0_pt_x, d0_pt_y;
    logic [ZW-1:0] d0_cmd_z, d0_pt_z;

    vector_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_draw(cmd_draw),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .busy(busy)
    );

    vector_sequencer #(.JUMP_PRE(0), .JUMP_POST(0), .DRAW_PRE(0), .DRAW_POST(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(d0_cmd_valid), .cmd_ready(d0_cmd_ready), .cmd_draw(d0_cmd_draw),
        .cmd_x(d0_cmd_x), .cmd_y(d0_cmd_y), .cmd_z(d0_cmd_z),
        .pt_valid(d0_pt_valid), .pt_ready(d0_pt_ready),
        .pt_x(d0_pt_x), .pt_y(d0_pt_y), .pt_z(d0_pt_z), .busy(d0_busy)
    );

    int total = 0;
    int bad = 0;

    typedef struct { int x; int y; int z; } pt_t;
    typedef struct { bit draw; int x; int y; int z; bit stall; int npts; } vec_t;

    pt_t  exp_q[$];
    int   m_x = 0;
    int   m_y = 0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] pk(input int x, input int y, input int z);
        return {32'd0, W'(x), W'(y), ZW'(z)};
    endfunction

    // Expected point list from the display rules: dwell at start, line, dwell at end.
    task automatic model_cmd(input bit draw, input int tx, input int ty, input int z);
        int zp, pre, post, dx, dy, sx, sy, maj, mnr, o;
        zp   = draw ? z : 0;
        pre  = draw ? DP : JP;
        post = draw ? DQ : JQ;
        for (int i = 0; i < pre; i++) exp_q.push_back('{m_x, m_y, zp});
        dx  = (tx >= m_x) ? tx - m_x : m_x - tx;
        dy  = (ty >= m_y) ? ty - m_y : m_y - ty;
        sx  = (tx >= m_x) ? 1 : -1;
        sy  = (ty >= m_y) ? 1 : -1;
        maj = (dx >= dy) ? dx : dy;
        mnr = (dx >= dy) ? dy : dx;
        if (!draw || maj == 0) begin
            exp_q.push_back('{tx, ty, zp});
        end else begin
            for (int i = 1; i <= maj; i++) begin
                o = (2 * i * mnr + maj - 1) / (2 * maj);
                if (dx >= dy) exp_q.push_back('{m_x + sx * i, m_y + sy * o, zp});
                else          exp_q.push_back('{m_x + sx * o, m_y + sy * i, zp});
            end
        end
        for (int i = 0; i < post; i++) exp_q.push_back('{tx, ty, zp});
    endtask

    task automatic run_cmd(input bit draw, input int tx, input int ty, input int z,
                           input bit stall, input int exp_n);
        int n_exp, got, cyc, bubbles;
        bit prev_stall;
        logic [63:0] saved;
        pt_t e;
        exp_q.delete();
        model_cmd(draw, tx, ty, z);
        n_exp = exp_q.size();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_draw = draw; cmd_x = W'(tx); cmd_y = W'(ty); cmd_z = ZW'(z);
        pt_ready = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin @(negedge clk); cyc++; end
        check("cmd_accept", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("first_valid", {63'd0, pt_valid}, 64'd1);
        check("busy_run", {63'd0, busy}, 64'd1);
        check("ready_low_busy", {63'd0, cmd_ready}, 64'd0);
        got = 0; cyc = 0; bubbles = 0; prev_stall = 1'b0; saved = '0;
        while (got < n_exp && cyc < 20000) begin
            if (prev_stall) check("stall_stable", {31'd0, pt_valid, pt_x, pt_y, pt_z}, saved);
            pt_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pt_valid && pt_ready) begin
                e = exp_q.pop_front();
                check("point", {32'd0, pt_x, pt_y, pt_z}, pk(e.x, e.y, e.z));
                got++;
            end else if (!pt_valid) begin
                bubbles++;
            end
            prev_stall = pt_valid && !pt_ready;
            saved = {31'd0, pt_valid, pt_x, pt_y, pt_z};
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20000) check("pt_timeout", 64'(cyc), 64'd0);
        pt_ready = 1'b1;
        check("idle_valid", {63'd0, pt_valid}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_ready", {63'd0, cmd_ready}, 64'd1);
        if (exp_n >= 0) check("npoints", 64'(got), 64'(exp_n));
        check("no_bubbles", 64'(bubbles), 64'd0);
        m_x = tx;
        m_y = ty;
    endtask

    // One zero-dwell command on dut0 that must produce exactly the listed points.
    task automatic run_d0(input bit draw, input int tx, input int ty, input int z,
                          input pt_t pts[$]);
        @(negedge clk);
        d0_cmd_valid = 1'b1; d0_cmd_draw = draw; d0_cmd_x = W'(tx); d0_cmd_y = W'(ty);
        d0_cmd_z = ZW'(z); d0_pt_ready = 1'b1;
        check("d0_cmd_ready", {63'd0, d0_cmd_ready}, 64'd1);
        @(negedge clk);
        d0_cmd_valid = 1'b0;
        foreach (pts[i]) begin
            check("d0_valid", {63'd0, d0_pt_valid}, 64'd1);
            check("d0_point", {32'd0, d0_pt_x, d0_pt_y, d0_pt_z}, pk(pts[i].x, pts[i].y, pts[i].z));
            @(negedge clk);
        end
        check("d0_done_valid", {63'd0, d0_pt_valid}, 64'd0);
        check("d0_done_busy", {63'd0, d0_busy}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pt_t zl[$];
        pt_t jp[$];
        pt_t ln[$];
        int cyc;
        cmd_valid = 1'b0; cmd_draw = 1'b0; cmd_x = '0; cmd_y = '0; cmd_z = '0; pt_ready = 1'b1;
        d0_cmd_valid = 1'b0; d0_cmd_draw = 1'b0; d0_cmd_x = '0; d0_cmd_y = '0; d0_cmd_z = '0;
        d0_pt_ready = 1'b1;

        vecs[0] = '{1'b0, 100, 200, 8'h00, 1'b0, JP + 1 + JQ};
        vecs[1] = '{1'b1, 104, 202, 8'hFF, 1'b0, DP + 4 + DQ};
        vecs[2] = '{1'b0, 0, 0, 8'h5A, 1'b0, JP + 1 + JQ};
        vecs[3] = '{1'b1, 4095, 0, 8'h80, 1'b0, DP + 4095 + DQ};
        vecs[4] = '{1'b1, 0, 4095, 8'h11, 1'b0, DP + 4095 + DQ};
        vecs[5] = '{1'b1, 0, 4095, 8'h22, 1'b0, DP + 1 + DQ};
        vecs[6] = '{1'b1, 10, 4090, 8'h33, 1'b0, DP + 10 + DQ};
        vecs[7] = '{1'b0, 4095, 4095, 8'h44, 1'b0, JP + 1 + JQ};
        vecs[8] = '{1'b1, 4094, 0, 8'h99, 1'b1, DP + 4095 + DQ};

        #12;
        check("rst_valid", {63'd0, pt_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_point", {32'd0, pt_x, pt_y, pt_z}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        foreach (vecs[i])
            run_cmd(vecs[i].draw, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].stall, vecs[i].npts);

        for (int i = 0; i < 16; i++)
            run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(0, 511),
                    $urandom_range(1, 255), 1'($urandom_range(0, 1)), -1);

        // Reset while the beam is mid-line.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_draw = 1'b1; cmd_x = W'(4000); cmd_y = W'(100); cmd_z = 8'h77;
        pt_ready = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_move_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, pt_valid}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_ready", {63'd0, cmd_ready}, 64'd0);
        check("arst_point", {32'd0, pt_x, pt_y, pt_z}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready_at_release", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        check("ready_post_release", {63'd0, cmd_ready}, 64'd1);
        m_x = 0;
        m_y = 0;
        run_cmd(1'b0, 1, 1, 8'h00, 1'b0, JP + 1 + JQ);

        // Zero-dwell instance: zero-length draw, bare jump, then a steep short line.
        zl.push_back('{0, 0, 8'h5A});
        run_d0(1'b1, 0, 0, 8'h5A, zl);
        jp.push_back('{7, 9, 0});
        run_d0(1'b0, 7, 9, 8'hEE, jp);
        ln.push_back('{8, 10, 8'h44});
        ln.push_back('{8, 11, 8'h44});
        ln.push_back('{9, 12, 8'h44});
        ln.push_back('{10, 13, 8'h44});
        run_d0(1'b1, 10, 13, 8'h44, ln);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
